// File: rtl/trig_lut_scheduler_pkg.sv
// Shared types and constants for the trig LUT scheduler: function codes,
// FSM state encoding, angle/result widths and the LUT one-hot enable helper.
package trig_lut_scheduler_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DFPU_WIDTH = 2 * DATA_WIDTH;

  localparam logic [1:0] FUNC_SIN = 2'd0;
  localparam logic [1:0] FUNC_COS = 2'd1;
  localparam logic [1:0] FUNC_TAN = 2'd2;
  localparam logic [1:0] FUNC_COT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // LUT enable bit order is {cot, tan, cos, sin}
  function automatic logic [3:0] func_onehot(input logic [1:0] func);
    logic [3:0] en;
    en = 4'b0000;
    case (func)
      FUNC_SIN: en = 4'b0001;
      FUNC_COS: en = 4'b0010;
      FUNC_TAN: en = 4'b0100;
      FUNC_COT: en = 4'b1000;
      default:  en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/trig_lut_scheduler_if.sv
// Requester/response bus between the calculator front-end (master) and the
// trig LUT scheduler (slave).
interface trig_lut_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import trig_lut_scheduler_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // valid must not depend on ready; ready may depend on valid. The
  // scheduler raises at most one req_ready bit and holds resp_* stable
  // until resp_ready.
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [2*NUM_REQ-1:0]          req_func;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_angle;
  logic                          resp_valid;
  logic                          resp_ready;
  logic [ID_W-1:0]               resp_id;
  logic                          resp_err;
  logic [DFPU_WIDTH-1:0]         resp_data;

  modport master (
    output req_valid, req_func, req_angle, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_err, resp_data
  );

  modport slave (
    input  req_valid, req_func, req_angle, resp_ready,
    output req_ready, resp_valid, resp_id, resp_err, resp_data
  );

endinterface

// File: rtl/trig_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer, wrapping around; grant is one-hot or zero.
module trig_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  int best;

  function automatic int rr_dist(input int idx, input int ptr);
    return (idx >= ptr) ? (idx - ptr) : (idx + NUM_REQ - ptr);
  endfunction

  // Smallest wrapped distance from the pointer wins
  always_comb begin
    best    = NUM_REQ;
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid_i[i] && (rr_dist(i, int'(ptr_i)) < best)) begin
        best = rr_dist(i, int'(ptr_i));
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid_i[i] && (rr_dist(i, int'(ptr_i)) == best)) begin
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trig_lut_scheduler.sv
// Shares one bank of degree-indexed trig LUTs among NUM_REQ requesters.
// Optional 1-entry result cache enabled by defining TRIG_SCHED_CACHE_EN.
module trig_lut_scheduler
  import trig_lut_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LUT_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  trig_lut_scheduler_if.slave   bus,
  output logic [3:0]            lut_en,
  output logic [1:0]            lut_quadrant,
  output logic [DATA_WIDTH-1:0] lut_angle,
  input  logic [DFPU_WIDTH-1:0] lut_data,
  output state_e                state_dbg_o
);

  localparam int ID_W = $clog2(NUM_REQ);

  state_e                state_q, state_d;
  logic [1:0]            func_q, func_d;
  logic [DATA_WIDTH-1:0] angle_q, angle_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [1:0]            quad_q, quad_d;
  logic [DATA_WIDTH-1:0] red_q, red_d;
  logic                  err_q, err_d;
  logic [DFPU_WIDTH-1:0] data_q, data_d;
  logic [1:0]            cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic [1:0]            quad_r;
  logic [DATA_WIDTH-1:0] red_r;
  logic                  range_err;
  logic                  wait_done;
  logic                  hit;
  logic [DFPU_WIDTH-1:0] cache_data;

  trig_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(ID_W)) u_arb (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  // Quadrant split by comparison and a single subtract
  always_comb begin
    quad_r    = 2'd0;
    red_r     = angle_q;
    range_err = 1'b0;
    if (angle_q >= DATA_WIDTH'(360)) begin
      range_err = 1'b1;
    end else if (angle_q >= DATA_WIDTH'(270)) begin
      quad_r = 2'd3;
      red_r  = angle_q - DATA_WIDTH'(270);
    end else if (angle_q >= DATA_WIDTH'(180)) begin
      quad_r = 2'd2;
      red_r  = angle_q - DATA_WIDTH'(180);
    end else if (angle_q >= DATA_WIDTH'(90)) begin
      quad_r = 2'd1;
      red_r  = angle_q - DATA_WIDTH'(90);
    end
  end

  assign wait_done = (state_q == ST_WAIT) && (cnt_q == 2'(LUT_LATENCY - 1));

`ifdef TRIG_SCHED_CACHE_EN
  logic                  c_valid_q;
  logic [1:0]            c_func_q;
  logic [DATA_WIDTH-1:0] c_angle_q;
  logic [DFPU_WIDTH-1:0] c_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_valid_q <= 1'b0;
      c_func_q  <= '0;
      c_angle_q <= '0;
      c_data_q  <= '0;
    end else if (wait_done) begin
      c_valid_q <= 1'b1;
      c_func_q  <= func_q;
      c_angle_q <= angle_q;
      c_data_q  <= lut_data;
    end
  end

  assign hit        = c_valid_q && (c_func_q == func_q) && (c_angle_q == angle_q);
  assign cache_data = c_data_q;
`else
  assign hit        = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      func_q  <= '0;
      angle_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      quad_q  <= '0;
      red_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      angle_q <= angle_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      quad_q  <= quad_d;
      red_q   <= red_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    func_d        = func_q;
    angle_d       = angle_q;
    id_d          = id_q;
    ptr_d         = ptr_q;
    quad_d        = quad_q;
    red_d         = red_q;
    err_d         = err_q;
    data_d        = data_q;
    cnt_d         = cnt_q;
    bus.req_ready = '0;
    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = reset ? '0 : grant;
        if (|grant) begin
          func_d  = bus.req_func[2*int'(grant_id) +: 2];
          angle_d = bus.req_angle[DATA_WIDTH*int'(grant_id) +: DATA_WIDTH];
          id_d    = grant_id;
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        quad_d = quad_r;
        red_d  = red_r;
        err_d  = range_err;
        cnt_d  = '0;
        if (range_err) begin
          data_d  = '0;
          state_d = ST_RESP;
        end else if (hit) begin
          data_d  = cache_data;
          state_d = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) begin
          data_d  = lut_data;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from state so an async reset clears them at once
  assign lut_en         = (state_q == ST_ISSUE) ? func_onehot(func_q) : 4'b0000;
  assign lut_quadrant   = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? quad_q : 2'd0;
  assign lut_angle      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? red_q : '0;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_id    = (state_q == ST_RESP) ? id_q : '0;
  assign bus.resp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
  assign bus.resp_data  = (state_q == ST_RESP) ? data_q : '0;
  assign state_dbg_o    = state_q;

endmodule
